// File: rtl/json_uart_rx.sv
// json_uart_rx: 8N1 UART receiver feeding a parser for single-key JSON frames {"K":digits}
// Ports:
//   clk       system clock
//   rst       synchronous active-low reset
//   uart_in   asynchronous UART RX line, idles high
//   key       ASCII key of the last good frame
//   value     parsed value of the last good frame
//   valid     one-cycle pulse when key/value update
//   err       one-cycle pulse on any error
//   err_code  0=framing, 1=syntax, 2=overflow; held until the next err
//   busy      high while a frame is open
// Option: define JSON_NEG_EN to accept one leading '-' and report value as two's complement.
module json_uart_rx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int MAX_DIGITS = 5,
   parameter int VAL_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             uart_in,
   output logic [7:0]       key,
   output logic [VAL_W-1:0] value,
   output logic             valid,
   output logic             err,
   output logic [1:0]       err_code,
   output logic             busy
);
   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(CPB);
   localparam int DW  = $clog2(MAX_DIGITS + 1);
   localparam int AW  = VAL_W + 4;
`ifdef JSON_NEG_EN
   localparam bit NEG_EN = 1'b1;
`else
   localparam bit NEG_EN = 1'b0;
`endif
   localparam logic [AW-1:0] LIM_U = {4'd0, {VAL_W{1'b1}}};
   localparam logic [AW-1:0] LIM_P = {5'd0, {(VAL_W-1){1'b1}}};
   localparam logic [AW-1:0] LIM_N = LIM_P + AW'(1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_t;
   typedef enum logic [2:0] {P_IDLE, P_Q1, P_KEY, P_Q2, P_COLON, P_DIG} p_t;
   logic [1:0]    sync;
   logic          rxd;
   rx_t           rx_st, rx_nxt;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_i;
   logic [7:0]    sh;
   logic          byte_stb, fe_stb, cnt_done, half_done;
   p_t            p_st, p_nxt;
   logic [7:0]    pkey;
   logic [AW-1:0] acc, acc_new, lim;
   logic [DW-1:0] ndig;
   logic          neg, is_dig, set_valid, set_err, ld_key, clr_acc, ld_dig, ld_neg;
   logic [1:0]    code;
   assign rxd       = sync[1];
   assign cnt_done  = cnt == CW'(CPB - 1);
   assign half_done = cnt == CW'(CPB / 2 - 1);
   always_comb begin
      rx_nxt = rx_st;
      case (rx_st)
         IDLE:    rx_nxt = rxd ? IDLE : START;
         START:   rx_nxt = !half_done ? START : rxd ? IDLE : DATA;
         DATA:    rx_nxt = (cnt_done && bit_i == 3'd7) ? STOP : DATA;
         STOP:    rx_nxt = cnt_done ? IDLE : STOP;
         default: rx_nxt = IDLE;
      endcase
   end
   // The shift register doubles as the received byte once byte_stb fires.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync     <= 2'b11;
         rx_st    <= IDLE;
         cnt      <= '0;
         bit_i    <= '0;
         sh       <= '0;
         byte_stb <= 1'b0;
         fe_stb   <= 1'b0;
      end else begin
         sync     <= {sync[0], uart_in};
         rx_st    <= rx_nxt;
         cnt      <= (rx_nxt != rx_st || (rx_st == DATA && cnt_done)) ? '0 : cnt + 1'b1;
         if (rx_st == DATA && cnt_done) begin
            sh    <= {rxd, sh[7:1]};
            bit_i <= bit_i + 1'b1;
         end
         byte_stb <= rx_st == STOP && cnt_done && rxd;
         fe_stb   <= rx_st == STOP && cnt_done && !rxd;
      end
   end
   assign is_dig  = sh >= "0" && sh <= "9";
   assign acc_new = (acc << 3) + (acc << 1) + AW'(sh[3:0]);
   assign lim     = !NEG_EN ? LIM_U : neg ? LIM_N : LIM_P;
   always_comb begin
      p_nxt     = p_st;
      set_valid = 1'b0;
      set_err   = 1'b0;
      code      = 2'd1;
      ld_key    = 1'b0;
      clr_acc   = 1'b0;
      ld_dig    = 1'b0;
      ld_neg    = 1'b0;
      if (fe_stb) begin
         set_err = 1'b1;
         code    = 2'd0;
         p_nxt   = P_IDLE;
      end else if (byte_stb) begin
         if (sh == "{") begin
            // An opening brace always starts a fresh frame; inside a frame it also flags a syntax error.
            set_err = p_st != P_IDLE;
            p_nxt   = P_Q1;
         end else begin
            case (p_st)
               P_IDLE:  p_nxt = P_IDLE;
               P_Q1:    begin set_err = sh != 8'h22; p_nxt = P_KEY; end
               P_KEY:   begin set_err = sh < "A" || sh > "Z"; ld_key = 1'b1; p_nxt = P_Q2; end
               P_Q2:    begin set_err = sh != 8'h22; p_nxt = P_COLON; end
               P_COLON: begin set_err = sh != ":"; clr_acc = 1'b1; p_nxt = P_DIG; end
               P_DIG: begin
                  if (is_dig) begin
                     ld_dig = 1'b1;
                     if (ndig == DW'(MAX_DIGITS) || acc_new > lim) begin
                        set_err = 1'b1;
                        code    = 2'd2;
                     end
                  end else if (sh == "}" && ndig != '0) begin
                     set_valid = 1'b1;
                     p_nxt     = P_IDLE;
                  end else if (NEG_EN && sh == "-" && ndig == '0 && !neg) begin
                     ld_neg = 1'b1;
                  end else begin
                     set_err = 1'b1;
                  end
               end
               default: p_nxt = P_IDLE;
            endcase
            if (set_err) p_nxt = P_IDLE;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         p_st     <= P_IDLE;
         pkey     <= '0;
         acc      <= '0;
         ndig     <= '0;
         neg      <= 1'b0;
         key      <= '0;
         value    <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
         err_code <= '0;
         busy     <= 1'b0;
      end else begin
         p_st  <= p_nxt;
         valid <= set_valid;
         err   <= set_err;
         busy  <= p_nxt != P_IDLE;
         if (set_err) err_code <= code;
         if (set_valid) begin
            key   <= pkey;
            value <= neg ? -acc[VAL_W-1:0] : acc[VAL_W-1:0];
         end
         if (ld_key) pkey <= sh;
         if (clr_acc) begin
            acc  <= '0;
            ndig <= '0;
            neg  <= 1'b0;
         end
         if (ld_dig) begin
            acc  <= acc_new;
            ndig <= ndig + 1'b1;
         end
         if (ld_neg) neg <= 1'b1;
      end
   end
endmodule

// File: tb/tb_json_uart_rx.sv
// tb_json_uart_rx: scoreboard bench for json_uart_rx with a frame-level reference model
module tb_json_uart_rx;
   localparam int CLK_FREQ   = 3200000;
   localparam int BAUD       = 100000;
   localparam int CPB        = CLK_FREQ / BAUD;
   localparam int MAX_DIGITS = 5;
   localparam int VAL_W      = 16;
`ifdef JSON_NEG_EN
   localparam bit NEG = 1'b1;
`else
   localparam bit NEG = 1'b0;
`endif
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             uart_in = 1'b1;
   logic [7:0]       key;
   logic [VAL_W-1:0] value;
   logic             valid, err, busy;
   logic [1:0]       err_code;
   typedef struct {
      bit is_err;
      int code;
      int key;
      int val;
   } ev_t;
   ev_t        expq[$];
   int         checks = 0;
   int         errors = 0;
   bit         open = 1'b0;
   logic [7:0] fb[$];
   logic [7:0] bad_set[7] = '{"x", 8'h22, ":", "}", "{", "5", "-"};
   always #5 clk = ~clk;
   json_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_DIGITS(MAX_DIGITS), .VAL_W(VAL_W)) dut (
      .clk(clk), .rst(rst), .uart_in(uart_in), .key(key), .value(value),
      .valid(valid), .err(err), .err_code(err_code), .busy(busy)
   );
   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction
   function automatic void push_err(input int c);
      ev_t e;
      e.is_err = 1'b1; e.code = c; e.key = 0; e.val = 0;
      expq.push_back(e);
      open = 1'b0;
   endfunction
   function automatic int mag_of(input int first, input int last);
      int m = 0;
      for (int i = first; i <= last; i++) m = m * 10 + int'(fb[i]) - 48;
      return m;
   endfunction
   // Whole-frame model: keeps the bytes seen since '{' and judges each new byte against the frame grammar.
   function automatic void model_byte(input logic [7:0] b);
      int n, first, lim, m;
      bit isneg, ok;
      ev_t e;
      if (!open) begin
         if (b == "{") begin open = 1'b1; fb.delete(); end
         return;
      end
      if (b == "{") begin
         push_err(1);
         open = 1'b1;
         fb.delete();
         return;
      end
      fb.push_back(b);
      n = fb.size();
      if (n <= 4) begin
         ok = n == 2 ? (b >= "A" && b <= "Z") : n == 4 ? b == ":" : b == 8'h22;
         if (!ok) push_err(1);
         return;
      end
      isneg = NEG && fb[4] == "-";
      first = isneg ? 5 : 4;
      if (b == "-") begin
         if (!(NEG && n == 5)) push_err(1);
         return;
      end
      if (b == "}") begin
         if (n - 1 == first) push_err(1);
         else begin
            m = mag_of(first, n - 2);
            e.is_err = 1'b0; e.code = 0; e.key = int'(fb[1]);
            e.val = isneg ? ((-m) & ((1 << VAL_W) - 1)) : m;
            expq.push_back(e);
            open = 1'b0;
         end
         return;
      end
      if (b >= "0" && b <= "9") begin
         lim = !NEG ? (1 << VAL_W) - 1 : isneg ? (1 << (VAL_W - 1)) : (1 << (VAL_W - 1)) - 1;
         if (n - first > MAX_DIGITS || mag_of(first, n - 1) > lim) push_err(2);
         return;
      end
      push_err(1);
   endfunction
   task automatic send_byte(input logic [7:0] b, input bit bad = 1'b0);
      if (bad) push_err(0);
      else model_byte(b);
      uart_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_in = b[i];
         repeat (CPB) @(negedge clk);
      end
      if (bad) begin
         uart_in = 1'b0;
         repeat (CPB / 2 + 6) @(negedge clk);
         uart_in = 1'b1;
         repeat (CPB / 2 - 6) @(negedge clk);
      end else begin
         uart_in = 1'b1;
         repeat (CPB) @(negedge clk);
      end
      repeat (CPB) @(negedge clk);
   endtask
   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask
   always @(negedge clk) begin : mon
      ev_t e;
      if (rst && (valid || err)) begin
         if (valid && err) begin
            checks++;
            errors++;
            $display("FAIL exclusive: valid and err high together");
         end
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected: valid=%0b err=%0b code=%0d key=0x%0h value=0x%0h, expected nothing",
                     valid, err, err_code, key, value);
         end else begin
            e = expq.pop_front();
            if (e.is_err) begin
               chk("err_strobe", {err, valid}, 2'b10);
               chk("err_code", err_code, e.code);
            end else begin
               chk("valid_strobe", {valid, err}, 2'b10);
               chk("key", key, e.key);
               chk("value", value, e.val);
            end
         end
      end
   end
   initial begin
      repeat (5) @(negedge clk);
      chk("rst_key", key, 0);
      chk("rst_value", value, 0);
      chk("rst_valid", valid, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      send_byte("{");
      chk("busy_open", busy, 1);
      send_str("\"T\":11");
      chk("busy_digits", busy, 1);
      send_byte("}");
      chk("busy_done", busy, 0);
      chk("t_key", key, 8'h54);
      chk("t_value", value, 11);
      send_str("{\"T\"11}");
      chk("busy_syntax", busy, 0);
      chk("syntax_code", err_code, 1);
      send_str("{\"A\":0}");
      chk("a_key", key, 8'h41);
      chk("a_value", value, 0);
      send_str("{\"A\":70000}");
      chk("ovf5_code", err_code, 2);
      send_str("{\"A\":123456}");
      repeat (100) @(negedge clk);
      chk("ovf6_code_held", err_code, 2);
      chk("ovf_value_held", value, 0);
      send_str("{\"B");
      send_byte("x", 1'b1);
      chk("fe_busy", busy, 0);
      chk("fe_code", err_code, 0);
      send_str("{\"B\":5}");
      chk("b_key", key, 8'h42);
      chk("b_value", value, 5);
      uart_in = 1'b0;
      repeat (10) @(negedge clk);
      uart_in = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("glitch_busy", busy, 0);
      chk("glitch_code", err_code, 0);
      send_str("{\"C\":");
      chk("c_busy", busy, 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      open = 1'b0;
      fb.delete();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_key", key, 0);
      send_str("{\"C\":42}");
      chk("c_key", key, 8'h43);
      chk("c_value", value, 42);
      send_str("{\"D\":-300}");
`ifdef JSON_NEG_EN
      chk("d_value", value, 16'hFED4);
`else
      chk("d_code", err_code, 1);
`endif
      for (int r = 0; r < 12; r++) begin
         logic [7:0] fr[$];
         int nd;
         fr = {"{", 8'h22, 8'(65 + $urandom_range(0, 25)), 8'h22, ":"};
         nd = $urandom_range(1, 6);
         for (int i = 0; i < nd; i++) fr.push_back(8'(48 + $urandom_range(0, 9)));
         fr.push_back("}");
         if ($urandom_range(0, 3) == 0) fr[$urandom_range(1, fr.size() - 1)] = bad_set[$urandom_range(0, 6)];
         for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
      end
      repeat (4 * CPB) @(negedge clk);
      chk("drain", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/json_uart_rx.md
Name: json_uart_rx

Overview:
Receive-side counterpart of the JSON-to-UART transmit path. Deserialises an 8N1 UART line and parses single-key JSON frames of the form {"K":digits}. Each well-formed frame produces one key/value result with a one-cycle valid strobe. Sits between the board RX pin and control logic that consumes commands sent by the host.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide; 434 at defaults)
MAX_DIGITS, 5, maximum decimal digits accepted in a value
VAL_W, 16, width of the value output

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset (rst=0 resets on the rising edge of clk)
uart_in  in  1  asynchronous UART RX line, idles high
key  out  8  ASCII key character of the last good frame
value  out  VAL_W  parsed value of the last good frame
valid  out  1  one-cycle pulse when key/value update
err  out  1  one-cycle pulse on any error
err_code  out  2  0=framing, 1=syntax, 2=overflow; held until the next err
busy  out  1  high while a frame is open (after '{', until '}' or error)

Behaviour:
- Reset: key=0, value=0, valid=0, err=0, err_code=0, busy=0. Both FSMs go to IDLE. Synchroniser flops are set to 1.
- Reset mid-byte or mid-frame discards all partial state. No valid or err is produced for the discarded data.
- uart_in passes through a 2-flop synchroniser before use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a low on the synchronised line moves to START and clears the counter.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If low, go to DATA. If high (false start), return to IDLE silently.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, emit an internal byte strobe. If 0, assert framing error: err pulse with err_code=0, frame aborted, busy cleared. In both cases go to IDLE.
- Parser FSM states: P_IDLE, P_Q1, P_KEY, P_Q2, P_COLON, P_DIG, advancing one state per received byte.
  - P_IDLE: '{' goes to P_Q1 and sets busy=1. All other bytes are ignored.
  - P_Q1: expects '"'.
  - P_KEY: expects any byte in 0x41-0x5A ('A'-'Z'); latch it as the pending key.
  - P_Q2: expects '"'.
  - P_COLON: expects ':'. Go to P_DIG and clear the accumulator and digit count.
  - P_DIG accepts:
    - '0'-'9': acc = acc*10 + digit, computed at VAL_W+4 bits; digit count increments.
    - '}' with digit count >= 1: one clock after the byte strobe, key and value are updated, valid pulses, busy clears, go to P_IDLE.
  - Any unexpected byte in P_Q1..P_DIG, including '}' with zero digits: err pulse with err_code=1, busy=0, go to P_IDLE.
  - Exception: '{' received in any state other than P_IDLE restarts the frame at P_Q1 with an err pulse, err_code=1.
  - Overflow: the digit count would exceed MAX_DIGITS, or acc exceeds 2^VAL_W-1. Result: err pulse with err_code=2, go to P_IDLE.
- valid and err are never asserted in the same cycle.
- Result latency: '}' stop-bit sample to valid is exactly 2 clk cycles (byte strobe, then output register).

Optional Feature:
JSON_NEG_EN
- Defined: P_DIG additionally accepts one '-' as the first byte after ':'. value is then two's-complement signed. The overflow limit becomes a magnitude of 2^(VAL_W-1) for negative values and 2^(VAL_W-1)-1 for positive values. A second '-', or a '-' after a digit, is a syntax error. A lone "-}" is a syntax error.
- Undefined: '-' is a syntax error (err_code=1), and value is unsigned.

Test Plan:
- Send bytes 7B 22 54 22 3A 31 31 7D ({"T":11}) at 115200 baud -> exactly one valid; key=0x54, value=11; busy high from the '{' stop bit until valid; err never pulses.
- Send {"T"11} -> err pulse with err_code=1 on the byte '1' (0x31); no valid; busy=0; a following {"A":0} gives key=0x41, value=0.
- Send {"A":70000} -> err_code=2 at the fifth digit; {"A":123456} -> err_code=2 at the sixth digit; no valid in either case.
- Drive one byte with its stop bit forced 0 in the middle of a frame -> err_code=0, busy=0; the next complete {"B":5} is reported correctly.
- Drive a 100-cycle low glitch on the idle line -> no byte is received, no err. Assert rst=0 for one cycle between ':' and the digits, then send {"C":42} -> only a single valid, with key=0x43, value=42.
- JSON_NEG_EN defined: {"D":-300} -> value=16'hFED4, valid. JSON_NEG_EN undefined: the same frame gives err_code=1 at the '-'.
